// File: rtl/aes_serial_frontend.sv
// aes_serial_frontend: multi-lane serial host front end for an AES core.
// Receives an 8-bit header, a 128-bit block and a 32*NK-bit key, LSB first,
// on LANES bits per clock while cs is high. It launches one core operation
// through a start/done handshake and then shifts the 128-bit result out on mosi.
// Optional build macro AES_FE_KEY_RETAIN_EN: when it is defined, header bit1
// skips the key phase and reuses the key of the previous launch.
module aes_serial_frontend #(
    parameter int NK    = 4,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [LANES-1:0]  miso,
    output logic [LANES-1:0]  mosi,
    output logic              core_start,
    output logic              core_decrypt,
    output logic [127:0]      core_data,
    output logic [32*NK-1:0]  core_key,
    input  logic [127:0]      core_result,
    input  logic              core_done,
    output logic              busy,
    output logic              frame_err
);

    localparam int KW         = 32 * NK;
    localparam int CW         = 9;
    localparam int HDR_BEATS  = 8 / LANES;
    localparam int DATA_BEATS = 128 / LANES;
    localparam int KEY_BEATS  = KW / LANES;
    localparam int TX_BEATS   = 128 / LANES;

    localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BEATS - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BEATS - 1);
    localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_BEATS - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(TX_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_HDR,
        S_RX_DATA,
        S_RX_KEY,
        S_WAIT_CORE,
        S_READY,
        S_TX
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dec_q, dec_d;
    logic [127:0]    rx_data_q, rx_data_d;
    logic [KW-1:0]   rx_key_q, rx_key_d;
    logic            core_dec_q, core_dec_d;
    logic [127:0]    core_data_q, core_data_d;
    logic [KW-1:0]   core_key_q, core_key_d;
    logic [127:0]    tx_q, tx_d;
    logic            armed_q, armed_d;
    logic            start_q, start_d;
    logic            err_q, err_d;

    logic [127:0]    data_shift;
    logic [KW-1:0]   key_shift;
    logic [127:0]    tx_shift;
    logic            skip_key;

    // New beats enter at the top so that after a full field the first beat sits at bit 0.
    assign data_shift = {miso, rx_data_q[127:LANES]};
    assign key_shift  = {miso, rx_key_q[KW-1:LANES]};
    assign tx_shift   = {{LANES{1'b0}}, tx_q[127:LANES]};

`ifdef AES_FE_KEY_RETAIN_EN
    localparam int B1_IDX = (LANES > 1) ? 1 : 0;
    logic keep_q, keep_d;
    assign skip_key = keep_q;
`else
    assign skip_key = 1'b0;
`endif

    assign core_start   = start_q;
    assign core_decrypt = core_dec_q;
    assign core_data    = core_data_q;
    assign core_key     = core_key_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_err    = err_q;
    assign mosi         = (state_q == S_READY || state_q == S_TX) ? tx_q[LANES-1:0] : '0;

    // State, counters, shift and holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dec_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_key_q    <= '0;
            core_dec_q  <= 1'b0;
            core_data_q <= '0;
            core_key_q  <= '0;
            tx_q        <= '0;
            armed_q     <= 1'b0;
            start_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef AES_FE_KEY_RETAIN_EN
            keep_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_q       <= dec_d;
            rx_data_q   <= rx_data_d;
            rx_key_q    <= rx_key_d;
            core_dec_q  <= core_dec_d;
            core_data_q <= core_data_d;
            core_key_q  <= core_key_d;
            tx_q        <= tx_d;
            armed_q     <= armed_d;
            start_q     <= start_d;
            err_q       <= err_d;
`ifdef AES_FE_KEY_RETAIN_EN
            keep_q      <= keep_d;
`endif
        end
    end

    // Frame sequencing: receive, launch, wait for the core, transmit, abort on early cs drop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_d       = dec_q;
        rx_data_d   = rx_data_q;
        rx_key_d    = rx_key_q;
        core_dec_d  = core_dec_q;
        core_data_d = core_data_q;
        core_key_d  = core_key_q;
        tx_d        = tx_q;
        armed_d     = armed_q;
        start_d     = 1'b0;
        err_d       = 1'b0;
`ifdef AES_FE_KEY_RETAIN_EN
        keep_d      = keep_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cs) begin
                    // Header bit0 always arrives on beat 0, lane 0.
                    dec_d = miso[0];
`ifdef AES_FE_KEY_RETAIN_EN
                    keep_d = (LANES > 1) ? miso[B1_IDX] : 1'b0;
`endif
                    if (HDR_BEATS == 1) begin
                        state_d = S_RX_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RX_HDR;
                        cnt_d   = CW'(1);
                    end
                end
            end

            S_RX_HDR: begin
                if (!cs) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
`ifdef AES_FE_KEY_RETAIN_EN
                    if (LANES == 1 && cnt_q == CW'(1)) begin
                        keep_d = miso[0];
                    end
`endif
                    if (cnt_q == HDR_LAST) begin
                        cnt_d   = '0;
                        state_d = S_RX_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_RX_DATA: begin
                if (!cs) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rx_data_d = data_shift;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
                        if (skip_key) begin
                            // Launch straight from the data phase; core_key keeps the previous key.
                            core_data_d = data_shift;
                            core_dec_d  = dec_q;
                            start_d     = 1'b1;
                            state_d     = S_WAIT_CORE;
                        end else begin
                            state_d = S_RX_KEY;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_RX_KEY: begin
                if (!cs) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rx_key_d = key_shift;
                    if (cnt_q == KEY_LAST) begin
                        cnt_d       = '0;
                        core_data_d = rx_data_q;
                        core_key_d  = key_shift;
                        core_dec_d  = dec_q;
                        start_d     = 1'b1;
                        state_d     = S_WAIT_CORE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_WAIT_CORE: begin
                if (core_done) begin
                    tx_d    = core_result;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_READY;
                end
            end

            S_READY: begin
                // The host must release cs at least once before the read frame starts.
                if (!cs) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    cnt_d   = '0;
                    state_d = S_TX;
                end
            end

            S_TX: begin
                if (!cs) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tx_d = tx_shift;
                    if (cnt_q == TX_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_serial_frontend.sv
// Scoreboard bench for aes_serial_frontend: one NK=4/LANES=1 instance and one
// NK=8/LANES=4 instance share a stimulus bus selected by sel.
`timescale 1ns/1ps
module tb_aes_serial_frontend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, cs, sel;
    logic [7:0]   miso;
    logic [127:0] result;
    logic         done;

    logic         cs_a, cs_b, done_a, done_b;
    logic [0:0]   mosi_a;
    logic [3:0]   mosi_b;
    logic         start_a, start_b, dec_a, dec_b, busy_a, busy_b, err_a, err_b;
    logic [127:0] data_a, data_b;
    logic [127:0] key_a;
    logic [255:0] key_b;

    assign cs_a   = cs & ~sel;
    assign cs_b   = cs & sel;
    assign done_a = done & ~sel;
    assign done_b = done & sel;

    aes_serial_frontend #(.NK(4), .LANES(1)) u_dut_a (
        .clk(clk), .rst(rst), .cs(cs_a), .miso(miso[0:0]), .mosi(mosi_a),
        .core_start(start_a), .core_decrypt(dec_a), .core_data(data_a), .core_key(key_a),
        .core_result(result), .core_done(done_a), .busy(busy_a), .frame_err(err_a)
    );

    aes_serial_frontend #(.NK(8), .LANES(4)) u_dut_b (
        .clk(clk), .rst(rst), .cs(cs_b), .miso(miso[3:0]), .mosi(mosi_b),
        .core_start(start_b), .core_decrypt(dec_b), .core_data(data_b), .core_key(key_b),
        .core_result(result), .core_done(done_b), .busy(busy_b), .frame_err(err_b)
    );

    logic         start_m, dec_m, busy_m, err_m;
    logic [127:0] data_m;
    logic [255:0] key_m;
    logic [7:0]   mosi_m;

    always_comb begin
        if (sel) begin
            start_m = start_b; dec_m = dec_b; busy_m = busy_b; err_m = err_b;
            data_m  = data_b;  key_m = key_b; mosi_m = {4'b0, mosi_b};
        end else begin
            start_m = start_a; dec_m = dec_a; busy_m = busy_a; err_m = err_a;
            data_m  = data_a;  key_m = {128'b0, key_a}; mosi_m = {7'b0, mosi_a};
        end
    end

    typedef struct packed {
        logic         dec;
        logic [127:0] data;
        logic [255:0] key;
    } launch_t;

    launch_t      exp_launch[$];
    logic [127:0] res_q[$];
    logic [127:0] exp_tx[$];
    launch_t      cur;
    bit           core_kill = 1'b0;
    int           vecs = 0;
    int           miss = 0;
    int           done_cnt = 0;
    int           err_cycles = 0;

    localparam logic [127:0] D1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] D2   = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R2   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_op(input logic dec, input logic [127:0] data, input logic [255:0] key,
                             input logic [127:0] res, input bit with_tx);
        launch_t l;
        l.dec = dec; l.data = data; l.key = key;
        exp_launch.push_back(l);
        res_q.push_back(res);
        if (with_tx) exp_tx.push_back(res);
    endtask

    // Drives nbeats beats (0 = whole frame) from a negedge, then drops cs.
    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] data, input logic [255:0] key,
                              input int nk, input int lanes, input int nbeats, input bit exp_start);
        logic [391:0] s, t;
        logic [7:0]   mask;
        int           total;
        s     = {key, data, hdr};
        mask  = 8'((1 << lanes) - 1);
        total = (nbeats > 0) ? nbeats : (136 + 32 * nk) / lanes;
        for (int b = 0; b < total; b++) begin
            t    = s >> (b * lanes);
            cs   = 1'b1;
            miso = t[7:0] & mask;
            @(negedge clk);
        end
        cs   = 1'b0;
        miso = '0;
        if (exp_start) chk("start_latency", {255'b0, start_m}, 256'd1);
    endtask

    task automatic rx_result(input int lanes);
        logic [127:0] exp, got;
        logic [7:0]   mask;
        int           d0, nb;
        bit           hit;
        exp  = exp_tx.pop_front();
        mask = 8'((1 << lanes) - 1);
        nb   = 128 / lanes;
        got  = '0;
        d0   = done_cnt;
        hit  = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (done_cnt != d0) hit = 1'b1;
        end
        if (!hit) begin
            vecs++; miss++;
            $display("FAIL done_timeout: no core_done within 200 cycles");
            return;
        end
        @(negedge clk);
        @(negedge clk);
        chk("ready_busy", {255'b0, busy_m}, 256'd1);
        chk("ready_mosi", {248'b0, mosi_m}, {248'b0, exp[7:0] & mask});
        cs = 1'b1;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            got = got | (128'(mosi_m & mask) << (k * lanes));
        end
        @(negedge clk);
        cs = 1'b0;
        chk("tx_result", {128'b0, got}, {128'b0, exp});
        chk("busy_after_tx", {255'b0, busy_m}, 256'd0);
        chk("mosi_after_tx", {248'b0, mosi_m}, 256'd0);
    endtask

    // Launch monitor: every core_start pops one expected launch.
    initial begin
        forever begin
            @(negedge clk);
            if (err_a | err_b) err_cycles++;
            if (rst && start_m) begin
                if (exp_launch.size() == 0) begin
                    vecs++; miss++;
                    $display("FAIL unexpected_start: core_start with no launch expected");
                end else begin
                    cur = exp_launch.pop_front();
                    chk("launch_dec", {255'b0, dec_m}, {255'b0, cur.dec});
                    chk("launch_data", {128'b0, data_m}, {128'b0, cur.data});
                    chk("launch_key", key_m, cur.key);
                end
            end
        end
    end

    // Core model: 12-cycle latency, checks operands are held, returns queued result.
    initial begin
        done   = 1'b0;
        result = '0;
        forever begin
            @(negedge clk);
            if (rst && start_m) begin
                repeat (11) @(negedge clk);
                if (!core_kill) begin
                    chk("hold_dec", {255'b0, dec_m}, {255'b0, cur.dec});
                    chk("hold_data", {128'b0, data_m}, {128'b0, cur.data});
                    chk("hold_key", key_m, cur.key);
                end
                result = (res_q.size() > 0) ? res_q.pop_front() : '0;
                done   = 1'b1;
                done_cnt++;
                @(negedge clk);
                done   = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit hit;
        rst = 1'b0; cs = 1'b0; sel = 1'b0; miso = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {252'b0, busy_m, start_m, dec_m, err_m}, 256'd0);
        chk("reset_data", {128'b0, data_m}, 256'd0);
        chk("reset_key", key_m, 256'd0);
        chk("reset_mosi", {248'b0, mosi_m}, 256'd0);
        rst = 1'b1;
        @(negedge clk);

        // Encrypt, NK=4, one lane.
        expect_op(1'b0, D1, {128'b0, K1}, R1, 1'b1);
        send_frame(8'h00, D1, {128'b0, K1}, 4, 1, 0, 1'b1);
        rx_result(1);

        // Decrypt, same frame.
        expect_op(1'b1, D1, {128'b0, K1}, D1, 1'b1);
        send_frame(8'h01, D1, {128'b0, K1}, 4, 1, 0, 1'b1);
        rx_result(1);

        // Abort after 50 data beats, then an immediate full frame.
        send_frame(8'h00, D2, {128'b0, K2}, 4, 1, 8 + 50, 1'b0);
        @(negedge clk);
        chk("abort_err", {255'b0, err_m}, 256'd1);
        chk("abort_busy", {255'b0, busy_m}, 256'd0);
        expect_op(1'b0, D2, {128'b0, K2}, R2, 1'b1);
        send_frame(8'h00, D2, {128'b0, K2}, 4, 1, 0, 1'b1);
        rx_result(1);

`ifdef AES_FE_KEY_RETAIN_EN
        expect_op(1'b0, D1, {128'b0, K2}, R1, 1'b1);
        send_frame(8'h00, D1, {128'b0, K2}, 4, 1, 0, 1'b1);
        rx_result(1);
        expect_op(1'b0, D2, {128'b0, K2}, R2, 1'b1);
        send_frame(8'h02, D2, 256'b0, 4, 1, 136, 1'b1);
        rx_result(1);
`else
        // Header bit1 has no effect: the key is still received.
        expect_op(1'b0, D2, {128'b0, K1}, R2, 1'b1);
        send_frame(8'h02, D2, {128'b0, K1}, 4, 1, 0, 1'b1);
        rx_result(1);
`endif

        // Reset during WAIT_CORE; the late core_done must be ignored.
        core_kill = 1'b1;
        expect_op(1'b1, D2, {128'b0, K2}, R2, 1'b0);
        send_frame(8'h01, D2, {128'b0, K2}, 4, 1, 0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_ctrl", {252'b0, busy_m, start_m, dec_m, err_m}, 256'd0);
        chk("midreset_data", {128'b0, data_m}, 256'd0);
        chk("midreset_key", key_m, 256'd0);
        chk("midreset_mosi", {248'b0, mosi_m}, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        d0  = done_cnt;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (done_cnt != d0) hit = 1'b1;
        end
        if (!hit) begin
            vecs++; miss++;
            $display("FAIL late_done_timeout: core model never pulsed done");
        end
        repeat (2) @(negedge clk);
        chk("late_done_busy", {255'b0, busy_m}, 256'd0);
        chk("late_done_mosi", {248'b0, mosi_m}, 256'd0);
        core_kill = 1'b0;

        // NK=8, four lanes: 98 receive beats, 32 transmit beats.
        sel = 1'b1;
        @(negedge clk);
        expect_op(1'b0, D1, K256, R3, 1'b1);
        send_frame(8'h00, D1, K256, 8, 4, 0, 1'b1);
        rx_result(4);

        repeat (4) @(negedge clk);
        chk("frame_err_cycles", 256'(err_cycles), 256'd1);
        chk("launch_queue_left", 256'(exp_launch.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
